// File: rtl/hit_result_join_pkg.sv
// Shared types and constants for the hit-point / normal join path.
package hit_pkg;

    localparam int FLOAT_SIZE = 32;
    localparam logic [FLOAT_SIZE-1:0] FLOAT_ONE = 32'h3F800000;

    // Element 0 is x, element 2 is z, so {z,y,x} concatenation maps directly.
    typedef logic [2:0][FLOAT_SIZE-1:0] vec3_t;

    typedef struct packed {
        vec3_t normal;
        vec3_t point;
        logic  invalid;
    } hit_rec_t;

    function automatic vec3_t mk_vec3(input logic [FLOAT_SIZE-1:0] x,
                                      input logic [FLOAT_SIZE-1:0] y,
                                      input logic [FLOAT_SIZE-1:0] z);
        return {z, y, x};
    endfunction

endpackage

// File: rtl/hit_result_join_fifo.sv
// Small AXI-Stream synchronous FIFO with first-word fall-through.
// An empty FIFO presents the incoming beat directly at its head, so a beat
// accepted in a cycle can also be consumed in that same cycle without being
// stored. A full FIFO never accepts, even if its head is popped that cycle.
module axis_sync_fifo
    import hit_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic store;
    logic take;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // Ready is purely a function of occupancy and reset; no look-ahead on pops.
    assign s_tready = !areset && !full;
    assign push     = s_tvalid && s_tready;

    assign m_tvalid = !empty || push;
    assign m_tdata  = empty ? s_tdata : mem[rd_ptr];
    assign pop      = m_tvalid && m_tready;

    // A beat that bypasses an empty FIFO is never written to storage.
    assign store = push && !(empty && pop);
    assign take  = pop && !empty;

    // Storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge aclk) begin
        if (store) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (take) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({store, take})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hit_result_join.sv
// Joins the hit-point and normal streams head to head, optionally drops
// records flagged as invalid-cylinder hits, and registers the result.
module hit_result_join
    import hit_pkg::*;
#(
    parameter int SIZE         = FLOAT_SIZE,
    parameter int DEPTH        = 4,
    parameter int DROP_INVALID = 1,
    parameter int CNT_W        = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [3*SIZE-1:0] hit_point_axis_tdata,
    input  logic              hit_point_axis_tvalid,
    output logic              hit_point_axis_tready,
    input  logic              invalid_cylinder_hit,
    input  logic [3*SIZE-1:0] normal_axis_tdata,
    input  logic              normal_axis_tvalid,
    output logic              normal_axis_tready,
    output logic [6*SIZE-1:0] hit_axis_tdata,
    output logic              hit_axis_invalid,
    output logic              hit_axis_tvalid,
    input  logic              hit_axis_tready,
    output logic [CNT_W-1:0]  record_count,
    output logic [CNT_W-1:0]  drop_count
);

    localparam int PW = 3*SIZE + 1;
    localparam int NW = 3*SIZE;

    logic [PW-1:0] pt_head;
    logic          pt_vld;
    logic [NW-1:0] nm_head;
    logic          nm_vld;

    logic join_go;
    logic drop_go;
    logic load_go;

    logic [6*SIZE-1:0] out_data;
    logic              out_inv;
    logic              out_vld;

    // Invalid flag rides in the top bit of the point FIFO word.
    axis_sync_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_pt_fifo (
        .aclk     (aclk),
        .areset   (areset),
        .s_tdata  ({invalid_cylinder_hit, hit_point_axis_tdata}),
        .s_tvalid (hit_point_axis_tvalid),
        .s_tready (hit_point_axis_tready),
        .m_tdata  (pt_head),
        .m_tvalid (pt_vld),
        .m_tready (join_go)
    );

    axis_sync_fifo #(.WIDTH(NW), .DEPTH(DEPTH)) u_nm_fifo (
        .aclk     (aclk),
        .areset   (areset),
        .s_tdata  (normal_axis_tdata),
        .s_tvalid (normal_axis_tvalid),
        .s_tready (normal_axis_tready),
        .m_tdata  (nm_head),
        .m_tvalid (nm_vld),
        .m_tready (join_go)
    );

    // Both heads pop together whenever the output slot is free or draining.
    assign join_go = pt_vld && nm_vld && (!out_vld || hit_axis_tready);
    assign drop_go = join_go && pt_head[PW-1] && (DROP_INVALID != 0);
    assign load_go = join_go && !drop_go;

    // Output register: reload on join, otherwise empty on handshake.
    always_ff @(posedge aclk) begin
        if (areset) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_inv  <= 1'b0;
        end else if (load_go) begin
            out_vld  <= 1'b1;
            out_data <= {nm_head, pt_head[NW-1:0]};
            out_inv  <= pt_head[PW-1];
        end else if (hit_axis_tready) begin
            out_vld  <= 1'b0;
        end
    end

    // Emitted and discarded record counters, wrapping silently.
    always_ff @(posedge aclk) begin
        if (areset) begin
            record_count <= '0;
            drop_count   <= '0;
        end else begin
            if (out_vld && hit_axis_tready) begin
                record_count <= record_count + CNT_W'(1);
            end
            if (drop_go) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    assign hit_axis_tdata   = out_data;
    assign hit_axis_invalid = out_inv;
    assign hit_axis_tvalid  = out_vld;

endmodule
